// File: rtl/image_plane_writer.sv
// image_plane_writer: level-shifts and saturates 8x8 IDCT tables and
// writes them as multi-pixel words into a planar multi-channel image RAM.
//
// Ports:
//   clk, rst                  clock, async active-low reset
//   image_table               packed signed samples, x + y*edge order
//   table_valid/table_ready   table handshake
//   frame_abort               synchronous frame restart
//   image_RAM_*               RAM write port with ready back-pressure
//   decoded_*_index           block/channel being (or next to be) written
//   image_generated           one-cycle pulse after the last frame word
module image_plane_writer #(
   parameter int IMAGE_WIDTH      = 320,
   parameter int IMAGE_HEIGHT     = 240,
   parameter int PIXEL_WIDTH      = 8,
   parameter int SAMPLE_WIDTH     = 9,
   parameter int DC_OFFSET        = 128,
   parameter int TABLE_EDGE_SIZE  = 8,
   parameter int NUM_CHANNELS     = 3,
   parameter int PIXELS_PER_WRITE = 2,
   localparam int TABLE_SIZE = TABLE_EDGE_SIZE * TABLE_EDGE_SIZE,
   localparam int BLOCK_WIDTH_SIZE  = IMAGE_WIDTH / TABLE_EDGE_SIZE,
   localparam int BLOCK_HEIGHT_SIZE = IMAGE_HEIGHT / TABLE_EDGE_SIZE,
   localparam int PLANE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT,
   localparam int IMAGE_RAM_ADDRESS_WIDTH =
      $clog2(NUM_CHANNELS * PLANE_SIZE),
   localparam int BLOCK_WIDTH_INDEX_SIZE =
      (BLOCK_WIDTH_SIZE > 1) ? $clog2(BLOCK_WIDTH_SIZE) : 1,
   localparam int BLOCK_HEIGHT_INDEX_SIZE =
      (BLOCK_HEIGHT_SIZE > 1) ? $clog2(BLOCK_HEIGHT_SIZE) : 1,
   localparam int CHANNEL_INDEX_SIZE =
      (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic [TABLE_SIZE*SAMPLE_WIDTH-1:0] image_table,
   input  logic table_valid,
   output logic table_ready,
   input  logic frame_abort,
   output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] image_RAM_address,
   output logic [PIXELS_PER_WRITE*PIXEL_WIDTH-1:0] image_RAM_data,
   output logic image_RAM_CE,
   output logic image_RAM_WE,
   input  logic image_RAM_ready,
   output logic [BLOCK_WIDTH_INDEX_SIZE-1:0] decoded_width_block_index,
   output logic [BLOCK_HEIGHT_INDEX_SIZE-1:0] decoded_height_block_index,
   output logic [CHANNEL_INDEX_SIZE-1:0] decoded_channel_index,
   output logic image_generated
);

   localparam int AW = IMAGE_RAM_ADDRESS_WIDTH;
   localparam int BWI = BLOCK_WIDTH_INDEX_SIZE;
   localparam int BHI = BLOCK_HEIGHT_INDEX_SIZE;
   localparam int CI = CHANNEL_INDEX_SIZE;
   localparam int WORDS_PER_ROW = TABLE_EDGE_SIZE / PIXELS_PER_WRITE;
   localparam int ROW_W = (TABLE_EDGE_SIZE > 1) ? $clog2(TABLE_EDGE_SIZE) : 1;
   localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam int SUM_W = SAMPLE_WIDTH + 2;
   localparam int TW = TABLE_SIZE * SAMPLE_WIDTH;

   localparam logic [CI-1:0] CH_LAST = CI'(NUM_CHANNELS - 1);
   localparam logic [BWI-1:0] BX_LAST = BWI'(BLOCK_WIDTH_SIZE - 1);
   localparam logic [BHI-1:0] BY_LAST = BHI'(BLOCK_HEIGHT_SIZE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TABLE_EDGE_SIZE - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_ROW - 1);
   localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIXEL_WIDTH) - 1);

   typedef enum logic [0:0] {IDLE, WRITE} state_t;

   state_t state_q;
   logic [TW-1:0] table_q;
   logic [CI-1:0] ch_q, ch_d;
   logic [BWI-1:0] bx_q, bx_d;
   logic [BHI-1:0] by_q, by_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic gen_q;
   logic last_word;
   logic frame_done_d;
   logic writing;
   logic [AW-1:0] addr;
   logic [PIXELS_PER_WRITE*PIXEL_WIDTH-1:0] data;

   assign writing = (state_q == WRITE);
   assign last_word = (row_q == ROW_LAST) && (col_q == COL_LAST);

   // Position after the word currently on the bus is accepted.
   always_comb begin
      ch_d = ch_q;
      bx_d = bx_q;
      by_d = by_q;
      row_d = row_q;
      col_d = col_q;
      frame_done_d = 1'b0;
      if (last_word) begin
         row_d = '0;
         col_d = '0;
         if (ch_q == CH_LAST) begin
            ch_d = '0;
            if (bx_q == BX_LAST) begin
               bx_d = '0;
               if (by_q == BY_LAST) begin
                  by_d = '0;
                  frame_done_d = 1'b1;
               end else begin
                  by_d = by_q + 1'b1;
               end
            end else begin
               bx_d = bx_q + 1'b1;
            end
         end else begin
            ch_d = ch_q + 1'b1;
         end
      end else if (col_q == COL_LAST) begin
         col_d = '0;
         row_d = row_q + 1'b1;
      end else begin
         col_d = col_q + 1'b1;
      end
   end

   always_comb begin
      logic [AW-1:0] x_pix;
      logic [AW-1:0] y_pix;
      x_pix = AW'(bx_q) * AW'(TABLE_EDGE_SIZE)
            + AW'(col_q) * AW'(PIXELS_PER_WRITE);
      y_pix = AW'(by_q) * AW'(TABLE_EDGE_SIZE) + AW'(row_q);
      addr = AW'(ch_q) * AW'(PLANE_SIZE)
           + x_pix + y_pix * AW'(IMAGE_WIDTH);
   end

   // Level shift with two guard bits so the sign of the sum is exact.
   always_comb begin
      logic [SAMPLE_WIDTH-1:0] smp;
      logic [SUM_W-1:0] sum;
      logic [PIXEL_WIDTH-1:0] pix;
      int idx;
      data = '0;
      smp = '0;
      sum = '0;
      pix = '0;
      idx = 0;
      for (int p = 0; p < PIXELS_PER_WRITE; p++) begin
         idx = int'(row_q) * TABLE_EDGE_SIZE
             + int'(col_q) * PIXELS_PER_WRITE + p;
         smp = table_q[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         sum = {{2{smp[SAMPLE_WIDTH-1]}}, smp} + SUM_W'(DC_OFFSET);
         if (sum[SUM_W-1]) begin
            pix = '0;
         end else if (sum > PIX_MAX) begin
            pix = '1;
         end else begin
            pix = sum[PIXEL_WIDTH-1:0];
         end
         data[p*PIXEL_WIDTH +: PIXEL_WIDTH] = pix;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         table_q <= '0;
         ch_q <= '0;
         bx_q <= '0;
         by_q <= '0;
         row_q <= '0;
         col_q <= '0;
         gen_q <= 1'b0;
      end else if (frame_abort) begin
         state_q <= IDLE;
         table_q <= '0;
         ch_q <= '0;
         bx_q <= '0;
         by_q <= '0;
         row_q <= '0;
         col_q <= '0;
         gen_q <= 1'b0;
      end else begin
         gen_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (table_valid) begin
                  table_q <= image_table;
                  row_q <= '0;
                  col_q <= '0;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               if (image_RAM_ready) begin
                  ch_q <= ch_d;
                  bx_q <= bx_d;
                  by_q <= by_d;
                  row_q <= row_d;
                  col_q <= col_d;
                  gen_q <= frame_done_d;
                  if (last_word) begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign table_ready = (state_q == IDLE);
   assign image_RAM_CE = writing;
   assign image_RAM_WE = writing;
   assign image_RAM_address = writing ? addr : '0;
   assign image_RAM_data = writing ? data : '0;
   assign decoded_width_block_index = bx_q;
   assign decoded_height_block_index = by_q;
   assign decoded_channel_index = ch_q;
   assign image_generated = gen_q;

endmodule
